counter_ctrl: RTL

Run-control sequencer for the board's 8-bit LED counter. It turns push-button presses into start/pause, direction and load commands, and generates its own count-enable tick from the 50 MHz clock, so the counter runs in a single clock domain. It sits between the key/switch inputs and `ledr`/hex decode in the top level, and drives the count value and status flags.

---
 rtl/counter_ctrl.sv | 128 ++++++++++++
 1 files changed

// File: rtl/counter_ctrl.sv
// Run-control sequencer for the 8-bit LED counter.
// The buttons are synchronized and debounced, and each accepted press becomes a single-cycle event.
// The events drive an IDLE/RUN/PAUSE sequencer and the direction flag.
// A prescaler that runs only in RUN produces the count steps.
// Every output is a register.
module counter_ctrl #(
  parameter int WIDTH      = 8,
  parameter int TICK_DIV   = 25_000_000,
  parameter int DEB_CYCLES = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       key_n,
  input  logic [WIDTH-1:0] sw_load,
  output logic [WIDTH-1:0] count,
  output logic             running,
  output logic             dir_down,
  output logic             tick,
  output logic             wrap
);

  localparam int PW = $clog2(TICK_DIV);
  localparam int DW = $clog2(DEB_CYCLES + 1);
  localparam logic [PW-1:0]    PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [DW-1:0]    DEB_FULL   = DW'(DEB_CYCLES);
  localparam logic [DW-1:0]    DEB_LAST   = DW'(DEB_CYCLES - 1);
  localparam logic [WIDTH-1:0] CNT_MAX    = '1;

  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

  logic [2:0]    key_p0;
  logic [2:0]    key_p1;
  logic [DW-1:0] deb_cnt [3];
  logic [2:0]    evt_p2;
  state_t        state;
  logic [PW-1:0] presc;

  logic ev_start;
  logic ev_dir;
  logic ev_load;

  assign ev_start = evt_p2[0];
  assign ev_dir   = evt_p2[1];
  assign ev_load  = evt_p2[2];

  // The counter value after one step, modulo 2^WIDTH.
  function automatic logic [WIDTH-1:0] step_value(input logic [WIDTH-1:0] cur, input logic down);
    return down ? cur - WIDTH'(1) : cur + WIDTH'(1);
  endfunction

  // This is true when the step from cur wraps the counter around.
  function automatic logic step_wraps(input logic [WIDTH-1:0] cur, input logic down);
    return down ? (cur == '0) : (cur == CNT_MAX);
  endfunction

  // Two-flop synchronizer per key; released (1) is the reset level
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      key_p0 <= 3'b111;
      key_p1 <= 3'b111;
    end else begin
      key_p0 <= key_n;
      key_p1 <= key_p0;
    end
  end

  // Debounce: count synchronized-low cycles and saturate, so each held press yields one event
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 3; i++) deb_cnt[i] <= '0;
      evt_p2 <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (key_p1[i])
          deb_cnt[i] <= '0;
        else if (deb_cnt[i] != DEB_FULL)
          deb_cnt[i] <= deb_cnt[i] + DW'(1);
        evt_p2[i] <= !key_p1[i] && (deb_cnt[i] == DEB_LAST);
      end
    end
  end

  // Sequencer, prescaler and counter; load beats start, and start beats step.
  // Direction toggles independently of the other events.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      presc    <= '0;
      count    <= '0;
      running  <= 1'b0;
      dir_down <= 1'b0;
      tick     <= 1'b0;
      wrap     <= 1'b0;
    end else begin
      tick <= 1'b0;
      wrap <= 1'b0;
      if (ev_dir)
        dir_down <= ~dir_down;
      if (ev_load) begin
        state   <= PAUSE;
        running <= 1'b0;
        presc   <= '0;
        count   <= sw_load;
      end else if (ev_start) begin
        presc <= '0;
        if (state == RUN) begin
          state   <= PAUSE;
          running <= 1'b0;
        end else begin
          state   <= RUN;
          running <= 1'b1;
        end
      end else if (state == RUN) begin
        if (presc == PRESC_LAST) begin
          presc <= '0;
          count <= step_value(count, dir_down);
          tick  <= 1'b1;
          wrap  <= step_wraps(count, dir_down);
        end else begin
          presc <= presc + PW'(1);
        end
      end else begin
        presc <= '0;
      end
    end
  end

endmodule
